// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for a fetch stage. Chooses the next fetch
//   address from sequential step, pc-relative branch or absolute jump,
//   defers a redirect that cannot advance yet, and diverts misaligned
//   targets and trap requests to TRAP_VECTOR.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_branch      sign-extended byte offset relative to pc
//   i_target      absolute jump target (bit 0 is cleared)
//   sel           00 seq, 01 relative, 10 absolute, 11 treated as seq
//   i_stall       pipeline hold
//   i_trap        trap request (highest priority once out of BOOT)
//   fetch_ready   fetch stage accepts the current pc
//   pc            current fetch address
//   pc_valid      pc is valid for fetch
//   pc_link       pc + INC, combinational
//   o_misaligned  one-cycle pulse after a misaligned redirect
//   o_bad_addr    last misaligned target
//
// States
//   state | meaning
//   BOOT  | first cycle after reset release, pc not yet valid
//   RUN   | normal sequencing
//   PEND  | redirect captured, waiting for the fetch stage to advance
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h0000_0100,
    parameter int              INC          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_branch,
    input  logic [XLEN-1:0] i_target,
    input  logic [1:0]      sel,
    input  logic            i_stall,
    input  logic            i_trap,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_link,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_bad_addr
);

    // INC is either 2 or 4, so alignment is a check of the low one or two bits
    localparam int ALIGN_W = (INC == 4) ? 2 : 1;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic            pend_mis_q, pend_mis_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] bad_q, bad_d;

    logic            adv;
    logic            redirect;
    logic [XLEN-1:0] tgt;
    logic            tgt_mis;
    logic [XLEN-1:0] apply_tgt;
    logic            apply_mis;

    assign pc_valid     = (state_q != BOOT);
    assign pc           = pc_q;
    assign pc_link      = pc_q + XLEN'(INC);
    assign o_misaligned = mis_q;
    assign o_bad_addr   = bad_q;

    assign adv      = pc_valid & fetch_ready & ~i_stall;
    assign redirect = (sel == 2'b01) || (sel == 2'b10);
    assign tgt      = (sel == 2'b01) ? (pc_q + i_branch) : (i_target & ~XLEN'(1));
    assign tgt_mis  = |tgt[ALIGN_W-1:0];

    // In PEND the stored target is applied; in RUN the live one is.
    assign apply_tgt = (state_q == PEND) ? pend_q     : tgt;
    assign apply_mis = (state_q == PEND) ? pend_mis_q : tgt_mis;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_mis_d = pend_mis_q;
        mis_d      = 1'b0;
        bad_d      = bad_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, PEND: begin
                if (i_trap) begin
                    pc_d       = TRAP_VECTOR;
                    pend_d     = '0;
                    pend_mis_d = 1'b0;
                    state_d    = RUN;
                end else if (state_q == PEND || redirect) begin
                    if (adv) begin
                        if (apply_mis) begin
                            pc_d  = TRAP_VECTOR;
                            mis_d = 1'b1;
                            bad_d = apply_tgt;
                        end else begin
                            pc_d = apply_tgt;
                        end
                        pend_d     = '0;
                        pend_mis_d = 1'b0;
                        state_d    = RUN;
                    end else if (state_q == RUN) begin
                        pend_d     = tgt;
                        pend_mis_d = tgt_mis;
                        state_d    = PEND;
                    end
                end else if (adv) begin
                    pc_d = pc_link;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            pend_mis_q <= 1'b0;
            mis_q      <= 1'b0;
            bad_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_mis_q <= pend_mis_d;
            mis_q      <= mis_d;
            bad_q      <= bad_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Drives an INC=4 and an INC=2 instance with identical stimulus and
//   compares both against a cycle-level reference model every cycle, with
//   directed scenarios followed by randomized traffic and random resets.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_branch;
    logic [31:0] i_target;
    logic [1:0]  sel;
    logic        i_stall;
    logic        i_trap;
    logic        fetch_ready;

    logic [31:0] pc4, link4, bad4;
    logic        valid4, mis4;
    logic [31:0] pc2, link2, bad2;
    logic        valid2, mis2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.INC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_branch(i_branch), .i_target(i_target),
        .sel(sel), .i_stall(i_stall), .i_trap(i_trap), .fetch_ready(fetch_ready),
        .pc(pc4), .pc_valid(valid4), .pc_link(link4),
        .o_misaligned(mis4), .o_bad_addr(bad4)
    );

    pc_sequencer #(.INC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_branch(i_branch), .i_target(i_target),
        .sel(sel), .i_stall(i_stall), .i_trap(i_trap), .fetch_ready(fetch_ready),
        .pc(pc2), .pc_valid(valid2), .pc_link(link2),
        .o_misaligned(mis2), .o_bad_addr(bad2)
    );

    // Reference model, index 0 is the INC=4 instance, index 1 the INC=2 one.
    logic [31:0] m_pc   [2];
    logic        m_boot [2];
    logic        m_has  [2];
    logic [31:0] m_ptgt [2];
    logic        m_mis  [2];
    logic [31:0] m_bad  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned inc_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = 32'h0;
            m_boot[k] = 1'b1;
            m_has[k]  = 1'b0;
            m_ptgt[k] = 32'h0;
            m_mis[k]  = 1'b0;
            m_bad[k]  = 32'h0;
        end
    endtask

    task automatic model_apply(input int k, input logic [31:0] t);
        if ((t % inc_of(k)) != 0) begin
            m_pc[k]  = 32'h100;
            m_mis[k] = 1'b1;
            m_bad[k] = t;
        end else begin
            m_pc[k] = t;
        end
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_clock();
        logic        adv;
        logic [31:0] t;
        if (!rst_n) begin
            model_reset();
            return;
        end
        adv = fetch_ready && !i_stall;
        for (int k = 0; k < 2; k++) begin
            m_mis[k] = 1'b0;
            if (m_boot[k]) begin
                m_boot[k] = 1'b0;
            end else if (i_trap) begin
                m_pc[k]  = 32'h100;
                m_has[k] = 1'b0;
            end else if (m_has[k]) begin
                if (adv) begin
                    model_apply(k, m_ptgt[k]);
                    m_has[k] = 1'b0;
                end
            end else if (sel == 2'd1 || sel == 2'd2) begin
                t = (sel == 2'd1) ? m_pc[k] + i_branch : {i_target[31:1], 1'b0};
                if (adv) begin
                    model_apply(k, t);
                end else begin
                    m_has[k]  = 1'b1;
                    m_ptgt[k] = t;
                end
            end else if (adv) begin
                m_pc[k] = m_pc[k] + inc_of(k);
            end
        end
    endtask

    task automatic check_all();
        chk("pc4",    pc4,           m_pc[0]);
        chk("valid4", 32'(valid4),   32'(!m_boot[0]));
        chk("link4",  link4,         m_pc[0] + 32'd4);
        chk("mis4",   32'(mis4),     32'(m_mis[0]));
        chk("bad4",   bad4,          m_bad[0]);
        chk("pc2",    pc2,           m_pc[1]);
        chk("valid2", 32'(valid2),   32'(!m_boot[1]));
        chk("link2",  link2,         m_pc[1] + 32'd2);
        chk("mis2",   32'(mis2),     32'(m_mis[1]));
        chk("bad2",   bad2,          m_bad[1]);
    endtask

    // Inputs are set at the falling edge; outputs are checked at the next one.
    task automatic cyc();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic [1:0] s, input logic [31:0] br, input logic [31:0] tg,
                          input logic fr, input logic st, input logic tr);
        sel = s; i_branch = br; i_target = tg; fetch_ready = fr; i_stall = st; i_trap = tr;
    endtask

    // Asynchronous reset pulse asserted mid-cycle, released at a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_pc_async", pc4, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        check_all();
        chk("reset_pc", pc4, 32'h0);
        chk("reset_valid", 32'(valid4), 32'h0);

        // Boot then sequential 0, 4, 8
        rst_n = 1'b1;
        #1;
        chk("boot_valid", 32'(valid4), 32'h0);
        cyc(); chk("seq0", pc4, 32'h0); chk("seq0_valid", 32'(valid4), 32'h1);
        cyc(); chk("seq4", pc4, 32'h4);
        cyc(); chk("seq8", pc4, 32'h8);

        // Backward relative branch from 0x100
        set_in(2'd2, 32'h0, 32'h100, 1'b1, 1'b0, 1'b0); cyc();
        chk("jmp100", pc4, 32'h100);
        set_in(2'd1, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 1'b0); cyc();
        chk("rel_back", pc4, 32'hF0);
        chk("rel_back_mis", 32'(mis4), 32'h0);

        // Deferred misaligned absolute jump
        set_in(2'd2, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0); cyc();
        chk("jmp20", pc4, 32'h20);
        set_in(2'd2, 32'h0, 32'h1003, 1'b0, 1'b0, 1'b0); cyc();
        chk("pend_hold1", pc4, 32'h20);
        set_in(2'd1, 32'h40, 32'h5550, 1'b0, 1'b0, 1'b0); cyc();
        chk("pend_hold2", pc4, 32'h20);
        set_in(2'd2, 32'h8, 32'h800, 1'b0, 1'b0, 1'b0); cyc();
        chk("pend_hold3", pc4, 32'h20);
        chk("pend_valid", 32'(valid4), 32'h1);
        set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); cyc();
        chk("pend_trap_pc", pc4, 32'h100);
        chk("pend_mis_pulse", 32'(mis4), 32'h1);
        chk("pend_bad", bad4, 32'h1002);
        chk("pend_inc2_pc", pc2, 32'h1002);
        cyc();
        chk("mis_one_cycle", 32'(mis4), 32'h0);
        chk("bad_held", bad4, 32'h1002);

        // Trap during a stalled PEND drops the pending target
        set_in(2'd2, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0); cyc();
        set_in(2'd2, 32'h0, 32'h40, 1'b1, 1'b1, 1'b1); cyc();
        chk("trap_pend", pc4, 32'h100);
        set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); cyc();
        chk("trap_dropped", pc4, 32'h104);

        // Wrap at the top of the address space
        set_in(2'd2, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0); cyc();
        chk("top_pc", pc4, 32'hFFFF_FFFC);
        chk("top_link", link4, 32'h0);
        set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0); cyc();
        chk("wrap", pc4, 32'h0);

        // Odd absolute target on the INC=2 instance
        set_in(2'd2, 32'h0, 32'h203, 1'b1, 1'b0, 1'b0); cyc();
        chk("inc2_abs", pc2, 32'h202);
        chk("inc2_nomis", 32'(mis2), 32'h0);
        chk("inc4_abs_mis", 32'(mis4), 32'h1);

        // Reset in the middle of PEND
        set_in(2'd2, 32'h0, 32'h300, 1'b0, 1'b0, 1'b0); cyc();
        do_reset();
        set_in(2'd2, 32'h0, 32'h500, 1'b1, 1'b0, 1'b1);
        cyc();
        chk("post_rst_pc", pc4, 32'h0);
        chk("post_rst_valid", 32'(valid4), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] tg;
            int          b;
            case ($urandom_range(0, 3))
                0:       tg = $urandom;
                1:       tg = 32'($urandom_range(0, 32'h400));
                2:       tg = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: tg = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'h4;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                b = int'($urandom_range(0, 64)) - 32;
                i_branch = 32'(b);
            end else begin
                i_branch = $urandom;
            end
            i_target    = tg;
            sel         = 2'($urandom_range(0, 3));
            fetch_ready = ($urandom_range(0, 3) != 0);
            i_stall     = ($urandom_range(0, 3) == 0);
            i_trap      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, PC value loaded on trap or misaligned target.
REQ-004 SHALL have parameter INC, default 4, sequential byte step; legal values 2 or 4.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port i_branch  in  XLEN  sign-extended byte offset, relative to the current pc.
REQ-008 SHALL have port i_target  in  XLEN  absolute jump target.
REQ-009 SHALL have port sel  in  2  next-PC mode: 00 sequential, 01 relative (pc+i_branch), 10 absolute (i_target with bit0 cleared), 11 reserved, treated as 00.
REQ-010 SHALL have port i_stall  in  1  pipeline hold.
REQ-011 SHALL have port i_trap  in  1  trap request.
REQ-012 SHALL have port fetch_ready  in  1  fetch stage accepts the current pc.
REQ-013 SHALL have port pc  out  XLEN  current fetch address.
REQ-014 SHALL have port pc_valid  out  1  pc is valid for fetch.
REQ-015 SHALL have port pc_link  out  XLEN  pc+INC modulo 2^XLEN, combinational.
REQ-016 SHALL have port o_misaligned  out  1  one-cycle pulse on a misaligned redirect.
REQ-017 SHALL have port o_bad_addr  out  XLEN  last misaligned target, held until the next one.

Function
REQ-018 SHALL define adv = pc_valid & fetch_ready & ~i_stall, evaluated each rising clk edge.
REQ-019 SHALL implement FSM states BOOT, RUN, PEND; BOOT lasts exactly one cycle after rst_n rises, then goes to RUN, with pc_valid=0 in BOOT and 1 in RUN/PEND.
REQ-020 SHALL compute target modulo 2^XLEN: mode 01 -> pc+i_branch; mode 10 -> i_target & ~1.
REQ-021 SHALL flag a target as misaligned when target mod INC != 0.
REQ-022 In RUN, when sel is in {01,10} and adv=1, SHALL load pc with target if aligned; if misaligned, SHALL load pc with TRAP_VECTOR, pulse o_misaligned, and capture target into o_bad_addr.
REQ-023 In RUN, when sel is in {01,10} and adv=0, SHALL capture target (and its misaligned flag) into a pending register, hold pc, and move to PEND.
REQ-024 In RUN, when sel is in {00,11} and adv=1, SHALL load pc with pc+INC, wrapping to 0 past 2^XLEN-1.
REQ-025 In RUN and PEND, when adv=0 and no trap is present, SHALL hold pc.
REQ-026 In PEND, SHALL ignore sel, i_branch and i_target.
REQ-027 In PEND, when adv=1, SHALL apply the pending target under the REQ-022 rules and return to RUN.
REQ-028 SHALL give i_trap highest priority in RUN and PEND, independent of adv, i_stall and fetch_ready: load pc with TRAP_VECTOR, discard any pending target, and go to RUN.
REQ-029 SHALL ignore i_trap while in BOOT.
REQ-030 SHALL raise o_misaligned only in the cycle following the redirect edge, for one cycle.
REQ-031 SHALL NOT cause pc to change when pc_valid=0.

Reset
REQ-032 While rst_n=0, SHALL immediately force: pc=RESET_VECTOR, pc_valid=0, o_misaligned=0, o_bad_addr=0, pending register=0, state=BOOT.
REQ-033 Reset asserted mid-PEND SHALL discard the pending target; after release, the first valid pc SHALL be RESET_VECTOR.

Verification
REQ-034 Reset release, fetch_ready=1, sel=00 -> pc_valid 0 for one cycle, then pc = 0x0, 0x4, 0x8 on successive cycles.
REQ-035 pc=0x100, sel=01, i_branch=0xFFFF_FFF0, adv=1 -> next pc=0xF0 and o_misaligned=0.
REQ-036 pc=0x20, sel=10, i_target=0x1003, fetch_ready=0 for 3 cycles, then fetch_ready=1 -> pc stays 0x20 in PEND for 3 cycles; pc_valid stays 1; i_target/sel changes are ignored; then pc=0x1002 is misaligned for INC=4, giving pc=0x100, a one-cycle o_misaligned pulse, and o_bad_addr=0x1002.
REQ-037 PEND with i_stall=1 plus i_trap=1 -> next pc=0x100, pending target dropped, state RUN.
REQ-038 pc=0xFFFF_FFFC, sel=00, adv=1 -> next pc=0x0; pc_link=0x0 while pc=0xFFFF_FFFC.
REQ-039 INC=2 instance, sel=10, i_target=0x203 -> pc=0x202, no misaligned pulse.
